// File: rtl/decode_stage_pipelined_pkg.sv
// decode_pkg: branch/jump op codes, forward select codes and the NOP instruction
package decode_pkg;
  localparam logic [3:0] BR_NONE = 4'd0;
  localparam logic [3:0] BR_BEQ  = 4'd1;
  localparam logic [3:0] BR_BNE  = 4'd2;
  localparam logic [3:0] BR_BLTZ = 4'd3;
  localparam logic [3:0] BR_BGEZ = 4'd4;
  localparam logic [3:0] BR_BLEZ = 4'd5;
  localparam logic [3:0] BR_BGTZ = 4'd6;
  localparam logic [3:0] BR_J    = 4'd7;
  localparam logic [3:0] BR_JAL  = 4'd8;
  localparam logic [3:0] BR_JR   = 4'd9;
  localparam logic [3:0] BR_JALR = 4'd10;
  localparam logic [1:0] FWD_RF      = 2'd0;
  localparam logic [1:0] FWD_ALUOUTM = 2'd1;
  localparam logic [1:0] FWD_RESULTW = 2'd2;
  localparam logic [1:0] FWD_RF_ALT  = 2'd3;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
endpackage

// File: rtl/decode_stage_pipelined_if.sv
// decode_stage_pipelined_if: fetch/hazard/writeback inputs and decode outputs of the decode stage
// master = driver of the stage (fetch, hazard unit, writeback), slave = decode stage
interface decode_stage_pipelined_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int INSTR_WIDTH   = 32,
  parameter int RF_ADDR_WIDTH = 5
);
  logic [INSTR_WIDTH-1:0]   i_InstrF;
  logic [ADDRESS_WIDTH-1:0] i_PCPlus4F;
  logic                     i_StallD;
  logic                     i_FlushD;
  logic [RF_ADDR_WIDTH-1:0] i_WriteRegW;
  logic                     i_RegWriteW;
  logic [DATA_WIDTH-1:0]    i_ResultW;
  logic [DATA_WIDTH-1:0]    i_ALUOutM;
  logic [1:0]               i_ForwardAD;
  logic [1:0]               i_ForwardBD;
  logic [3:0]               i_BranchOpD;
  logic [INSTR_WIDTH-1:0]   o_InstrD;
  logic [ADDRESS_WIDTH-1:0] o_PCPlus4D;
  logic                     o_ValidD;
  logic [DATA_WIDTH-1:0]    o_SrcAD;
  logic [DATA_WIDTH-1:0]    o_SrcBD;
  logic [DATA_WIDTH-1:0]    o_SignImmD;
  logic [4:0]               o_ShamtD;
  logic                     o_PCSrcD;
  logic [ADDRESS_WIDTH-1:0] o_PCNextD;
  modport master (
    output i_InstrF, i_PCPlus4F, i_StallD, i_FlushD, i_WriteRegW, i_RegWriteW,
           i_ResultW, i_ALUOutM, i_ForwardAD, i_ForwardBD, i_BranchOpD,
    input  o_InstrD, o_PCPlus4D, o_ValidD, o_SrcAD, o_SrcBD, o_SignImmD,
           o_ShamtD, o_PCSrcD, o_PCNextD
  );
  modport slave (
    input  i_InstrF, i_PCPlus4F, i_StallD, i_FlushD, i_WriteRegW, i_RegWriteW,
           i_ResultW, i_ALUOutM, i_ForwardAD, i_ForwardBD, i_BranchOpD,
    output o_InstrD, o_PCPlus4D, o_ValidD, o_SrcAD, o_SrcBD, o_SignImmD,
           o_ShamtD, o_PCSrcD, o_PCNextD
  );
endinterface

// File: rtl/decode_stage_pipelined_regfile_wt.sv
// regfile_wt: 2-read/1-write register file, register 0 hardwired to zero, write-through reads
// ports: i_CLK/i_RST, read indices i_RA1/i_RA2 -> o_RD1/o_RD2, write i_WE/i_WA/i_WD
module regfile_wt #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  i_CLK,
  input  logic                  i_RST,
  input  logic [ADDR_WIDTH-1:0] i_RA1,
  input  logic [ADDR_WIDTH-1:0] i_RA2,
  input  logic                  i_WE,
  input  logic [ADDR_WIDTH-1:0] i_WA,
  input  logic [DATA_WIDTH-1:0] i_WD,
  output logic [DATA_WIDTH-1:0] o_RD1,
  output logic [DATA_WIDTH-1:0] o_RD2
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  always_ff @(posedge i_CLK or posedge i_RST)
    if (i_RST) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_WE && i_WA != '0) r_mem[i_WA] <= i_WD;
  // same-cycle writeback bypasses the array so no half-cycle write is needed
  assign o_RD1 = (i_RA1 == '0) ? '0 : (i_WE && i_WA == i_RA1) ? i_WD : r_mem[i_RA1];
  assign o_RD2 = (i_RA2 == '0) ? '0 : (i_WE && i_WA == i_RA2) ? i_WD : r_mem[i_RA2];
endmodule

// File: rtl/decode_stage_pipelined.sv
// decode_stage_pipelined: IF/ID register, register file, operand forwarding and branch/jump resolution
// ports: i_CLK, i_RST (async, active high), bus (decode_stage_pipelined_if.slave)
module decode_stage_pipelined import decode_pkg::*; #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int INSTR_WIDTH   = 32,
  parameter int RF_ADDR_WIDTH = 5
) (
  input logic i_CLK,
  input logic i_RST,
  decode_stage_pipelined_if.slave bus
);
  logic [INSTR_WIDTH-1:0]   r_InstrD;
  logic [ADDRESS_WIDTH-1:0] r_PCPlus4D;
  logic                     r_ValidD;
  logic [RF_ADDR_WIDTH-1:0] w_rs, w_rt;
  logic [DATA_WIDTH-1:0]    w_rd1, w_rd2, w_SrcA, w_SrcB, w_SignImm;
  logic [15:0]              w_imm;
  logic [ADDRESS_WIDTH-1:0] w_br_tgt, w_j_tgt, w_jr_tgt, w_PCNext;
  logic                     w_neg, w_zero, w_cond;
  always_ff @(posedge i_CLK or posedge i_RST)
    if (i_RST || bus.i_FlushD) begin
      r_InstrD   <= INSTR_WIDTH'(NOP_INSTR);
      r_PCPlus4D <= '0;
      r_ValidD   <= 1'b0;
    end else if (!bus.i_StallD) begin
      r_InstrD   <= bus.i_InstrF;
      r_PCPlus4D <= bus.i_PCPlus4F;
      r_ValidD   <= 1'b1;
    end
  assign w_rs  = RF_ADDR_WIDTH'(r_InstrD[25:21]);
  assign w_rt  = RF_ADDR_WIDTH'(r_InstrD[20:16]);
  assign w_imm = r_InstrD[15:0];
  regfile_wt #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(RF_ADDR_WIDTH)) u_rf (
    .i_CLK (i_CLK),
    .i_RST (i_RST),
    .i_RA1 (w_rs),
    .i_RA2 (w_rt),
    .i_WE  (bus.i_RegWriteW),
    .i_WA  (bus.i_WriteRegW),
    .i_WD  (bus.i_ResultW),
    .o_RD1 (w_rd1),
    .o_RD2 (w_rd2)
  );
  assign w_SrcA = (bus.i_ForwardAD == FWD_ALUOUTM) ? bus.i_ALUOutM :
                  (bus.i_ForwardAD == FWD_RESULTW) ? bus.i_ResultW : w_rd1;
  assign w_SrcB = (bus.i_ForwardBD == FWD_ALUOUTM) ? bus.i_ALUOutM :
                  (bus.i_ForwardBD == FWD_RESULTW) ? bus.i_ResultW : w_rd2;
  assign w_SignImm = DATA_WIDTH'($signed(w_imm));
  assign w_neg  = w_SrcA[DATA_WIDTH-1];
  assign w_zero = (w_SrcA == '0);
  // branch offset is sign-extended at the address width, then wraps modulo 2**ADDRESS_WIDTH
  assign w_br_tgt = r_PCPlus4D + ADDRESS_WIDTH'($signed({w_imm, 2'b00}));
  // jump keeps every PC bit above bit 27 and replaces the low 28 bits
  assign w_j_tgt  = (r_PCPlus4D & ~ADDRESS_WIDTH'({28{1'b1}})) | ADDRESS_WIDTH'({r_InstrD[25:0], 2'b00});
  assign w_jr_tgt = ADDRESS_WIDTH'(w_SrcA);
  always_comb begin
    w_cond   = 1'b0;
    w_PCNext = r_PCPlus4D;
    case (bus.i_BranchOpD)
      BR_BEQ:         begin w_cond = (w_SrcA == w_SrcB); w_PCNext = w_br_tgt; end
      BR_BNE:         begin w_cond = (w_SrcA != w_SrcB); w_PCNext = w_br_tgt; end
      BR_BLTZ:        begin w_cond = w_neg;              w_PCNext = w_br_tgt; end
      BR_BGEZ:        begin w_cond = !w_neg;             w_PCNext = w_br_tgt; end
      BR_BLEZ:        begin w_cond = w_neg || w_zero;    w_PCNext = w_br_tgt; end
      BR_BGTZ:        begin w_cond = !w_neg && !w_zero;  w_PCNext = w_br_tgt; end
      BR_J, BR_JAL:   begin w_cond = 1'b1;               w_PCNext = w_j_tgt;  end
      BR_JR, BR_JALR: begin w_cond = 1'b1;               w_PCNext = w_jr_tgt; end
      default: ;
    endcase
  end
  assign bus.o_InstrD   = r_InstrD;
  assign bus.o_PCPlus4D = r_PCPlus4D;
  assign bus.o_ValidD   = r_ValidD;
  assign bus.o_SrcAD    = w_SrcA;
  assign bus.o_SrcBD    = w_SrcB;
  assign bus.o_SignImmD = w_SignImm;
  assign bus.o_ShamtD   = r_InstrD[10:6];
  assign bus.o_PCSrcD   = r_ValidD && w_cond;
  assign bus.o_PCNextD  = w_PCNext;
endmodule

// File: tb/tb_decode_stage_pipelined.sv
// tb_decode_stage_pipelined: directed scoreboard bench for decode_stage_pipelined
module tb_decode_stage_pipelined;
  import decode_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  decode_stage_pipelined_if bus();
  decode_stage_pipelined dut (.i_CLK(clk), .i_RST(rst), .bus(bus));
  typedef enum int {O_INSTR, O_PC4, O_VALID, O_SRCA, O_SRCB, O_IMM, O_SHAMT, O_PCSRC, O_PCNEXT} sel_e;
  typedef struct {string tag; sel_e sel; logic [31:0] exp;} exp_t;
  exp_t sb[$];
  int passes = 0;
  int total = 0;
  function automatic logic [31:0] observe(sel_e s);
    case (s)
      O_INSTR: return bus.o_InstrD;
      O_PC4:   return bus.o_PCPlus4D;
      O_VALID: return 32'(bus.o_ValidD);
      O_SRCA:  return bus.o_SrcAD;
      O_SRCB:  return bus.o_SrcBD;
      O_IMM:   return bus.o_SignImmD;
      O_SHAMT: return 32'(bus.o_ShamtD);
      O_PCSRC: return 32'(bus.o_PCSrcD);
      default: return bus.o_PCNextD;
    endcase
  endfunction
  task automatic expect_val(string tag, sel_e s, logic [31:0] v);
    exp_t e;
    e.tag = tag; e.sel = s; e.exp = v;
    sb.push_back(e);
  endtask
  task automatic verify();
    exp_t e;
    logic [31:0] o;
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = observe(e.sel);
      total++;
      assert (o === e.exp) passes++;
      else $error("FAIL %s observed=%h expected=%h", e.tag, o, e.exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic load(logic [31:0] ins, logic [31:0] pc);
    bus.i_InstrF = ins;
    bus.i_PCPlus4F = pc;
    bus.i_StallD = 1'b0;
    bus.i_FlushD = 1'b0;
    step();
  endtask
  initial begin
    bus.i_InstrF = '0; bus.i_PCPlus4F = '0; bus.i_StallD = 0; bus.i_FlushD = 0;
    bus.i_WriteRegW = '0; bus.i_RegWriteW = 0; bus.i_ResultW = '0; bus.i_ALUOutM = '0;
    bus.i_ForwardAD = FWD_RF; bus.i_ForwardBD = FWD_RF; bus.i_BranchOpD = BR_NONE;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    expect_val("rst_instr", O_INSTR, 0);
    expect_val("rst_pc4", O_PC4, 0);
    expect_val("rst_valid", O_VALID, 0);
    expect_val("rst_srca", O_SRCA, 0);
    expect_val("rst_srcb", O_SRCB, 0);
    expect_val("rst_imm", O_IMM, 0);
    expect_val("rst_shamt", O_SHAMT, 0);
    expect_val("rst_pcsrc", O_PCSRC, 0);
    expect_val("rst_pcnext", O_PCNEXT, 0);
    verify();
    // write-through to r5, then stored value
    load({6'd0, 5'd5, 5'd0, 16'd0}, 32'h10);
    bus.i_RegWriteW = 1; bus.i_WriteRegW = 5'd5; bus.i_ResultW = 32'h1234;
    expect_val("wt_r5", O_SRCA, 32'h1234);
    expect_val("valid_load", O_VALID, 1);
    verify();
    step();
    bus.i_RegWriteW = 0; bus.i_ResultW = 32'h5555;
    expect_val("stored_r5", O_SRCA, 32'h1234);
    verify();
    // r0 write ignored
    load({6'd0, 5'd0, 5'd5, 16'd0}, 32'h14);
    bus.i_RegWriteW = 1; bus.i_WriteRegW = 5'd0; bus.i_ResultW = 32'hFFFF;
    expect_val("wt_r0", O_SRCA, 0);
    expect_val("rt_r5", O_SRCB, 32'h1234);
    verify();
    step();
    bus.i_RegWriteW = 0;
    expect_val("stored_r0", O_SRCA, 0);
    verify();
    // BEQ backwards with SrcA forwarded from MEM, r2=7 written on the load edge
    bus.i_RegWriteW = 1; bus.i_WriteRegW = 5'd2; bus.i_ResultW = 32'd7;
    load(32'h1022FFFF, 32'h100);
    bus.i_RegWriteW = 0; bus.i_ResultW = 32'd0;
    bus.i_BranchOpD = BR_BEQ; bus.i_ForwardAD = FWD_ALUOUTM; bus.i_ALUOutM = 32'd7;
    expect_val("beq_srca", O_SRCA, 7);
    expect_val("beq_srcb", O_SRCB, 7);
    expect_val("beq_imm", O_IMM, 32'hFFFFFFFF);
    expect_val("beq_taken", O_PCSRC, 1);
    expect_val("beq_target", O_PCNEXT, 32'hFC);
    verify();
    bus.i_ALUOutM = 32'd8;
    expect_val("beq_nt", O_PCSRC, 0);
    expect_val("beq_nt_target", O_PCNEXT, 32'hFC);
    verify();
    bus.i_BranchOpD = BR_BNE;
    expect_val("bne_taken", O_PCSRC, 1);
    verify();
    // signed compares against zero
    bus.i_ALUOutM = 32'h80000000;
    bus.i_BranchOpD = BR_BLTZ; expect_val("bltz_neg", O_PCSRC, 1); verify();
    bus.i_BranchOpD = BR_BGTZ; expect_val("bgtz_neg", O_PCSRC, 0); verify();
    bus.i_BranchOpD = BR_BGEZ; expect_val("bgez_neg", O_PCSRC, 0); verify();
    bus.i_ALUOutM = 32'd0;
    bus.i_BranchOpD = BR_BLEZ; expect_val("blez_zero", O_PCSRC, 1); verify();
    bus.i_BranchOpD = BR_BGTZ; expect_val("bgtz_zero", O_PCSRC, 0); verify();
    bus.i_BranchOpD = BR_BGEZ; expect_val("bgez_zero", O_PCSRC, 1); verify();
    bus.i_BranchOpD = BR_BLTZ; expect_val("bltz_zero", O_PCSRC, 0); verify();
    // flush wins over stall
    bus.i_StallD = 1; bus.i_FlushD = 1; bus.i_InstrF = 32'h12345678;
    step();
    bus.i_BranchOpD = BR_BGEZ;
    expect_val("flush_instr", O_INSTR, 0);
    expect_val("flush_valid", O_VALID, 0);
    expect_val("flush_pc4", O_PC4, 0);
    expect_val("flush_pcsrc", O_PCSRC, 0);
    verify();
    // stall holds for three cycles
    load(32'h0041_07C0, 32'h200);
    bus.i_StallD = 1; bus.i_InstrF = 32'hDEADBEEF; bus.i_PCPlus4F = 32'h999;
    for (int i = 0; i < 3; i++) begin
      step();
      expect_val($sformatf("stall_instr%0d", i), O_INSTR, 32'h004107C0);
      expect_val($sformatf("stall_pc4%0d", i), O_PC4, 32'h200);
      verify();
    end
    expect_val("shamt", O_SHAMT, 5'd31);
    verify();
    // JR from WB forward
    bus.i_BranchOpD = BR_JR; bus.i_ForwardAD = FWD_RESULTW; bus.i_ResultW = 32'h00400020;
    expect_val("jr_taken", O_PCSRC, 1);
    expect_val("jr_target", O_PCNEXT, 32'h00400020);
    verify();
    // J keeps upper PC bits
    load(32'h08000010, 32'h40000004);
    bus.i_BranchOpD = BR_J;
    expect_val("j_taken", O_PCSRC, 1);
    expect_val("j_target", O_PCNEXT, 32'h40000040);
    verify();
    bus.i_BranchOpD = BR_NONE;
    expect_val("none_pcsrc", O_PCSRC, 0);
    expect_val("none_target", O_PCNEXT, 32'h40000004);
    verify();
    bus.i_BranchOpD = 4'd14;
    expect_val("undef_pcsrc", O_PCSRC, 0);
    expect_val("undef_target", O_PCNEXT, 32'h40000004);
    verify();
    // reset mid-cycle aborts a taken BEQ
    bus.i_ForwardAD = FWD_RF; bus.i_InstrF = 32'h0;
    load(32'h10000000, 32'h300);
    bus.i_BranchOpD = BR_BEQ;
    expect_val("pre_rst_taken", O_PCSRC, 1);
    expect_val("pre_rst_target", O_PCNEXT, 32'h300);
    verify();
    #2 rst = 1'b1;
    expect_val("async_rst_valid", O_VALID, 0);
    expect_val("async_rst_pcsrc", O_PCSRC, 0);
    expect_val("async_rst_target", O_PCNEXT, 0);
    verify();
    step();
    rst = 1'b0;
    bus.i_BranchOpD = BR_NONE;
    load({6'd0, 5'd5, 5'd2, 16'd0}, 32'h20);
    expect_val("rf_cleared_r5", O_SRCA, 0);
    expect_val("rf_cleared_r2", O_SRCB, 0);
    verify();
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule

// File: doc/decode_stage_pipelined.md
# decode_stage_pipelined

Parametrised successor of the MIPS decode stage that owns the IF/ID pipeline register, the register file, operand forwarding and full branch/jump resolution. It captures the fetched instruction under stall/flush control, reads operands through a write-through register file, selects forwarded values from MEM or WB, and resolves taken/not-taken plus the next PC in the decode cycle. It sits between the fetch stage and the ID/EX register, driven by the hazard unit and control unit.

## Interface
- DATA_WIDTH, 32, register/operand width
- ADDRESS_WIDTH, 32, PC width (≥ 28)
- INSTR_WIDTH, 32, instruction width
- RF_ADDR_WIDTH, 5, register index width; register file depth = 2**RF_ADDR_WIDTH
- i_CLK  in  1  clock, rising edge
- i_RST  in  1  asynchronous, active-high reset
- i_InstrF  in  INSTR_WIDTH  fetched instruction
- i_PCPlus4F  in  ADDRESS_WIDTH  fetch PC+4
- i_StallD  in  1  hold IF/ID register
- i_FlushD  in  1  load bubble into IF/ID register
- i_WriteRegW  in  RF_ADDR_WIDTH  writeback register index
- i_RegWriteW  in  1  writeback enable
- i_ResultW  in  DATA_WIDTH  writeback data
- i_ALUOutM  in  DATA_WIDTH  MEM-stage ALU result for forwarding
- i_ForwardAD, i_ForwardBD  in  2 each  forward select: 0 RF, 1 ALUOutM, 2 ResultW, 3 RF
- i_BranchOpD  in  4  branch/jump op code (package encoding)
- o_InstrD  out  INSTR_WIDTH  registered instruction
- o_PCPlus4D  out  ADDRESS_WIDTH  registered PC+4
- o_ValidD  out  1  IF/ID holds a real instruction
- o_SrcAD, o_SrcBD  out  DATA_WIDTH  forwarded operands
- o_SignImmD  out  DATA_WIDTH  sign-extended imm[15:0]
- o_ShamtD  out  5  instr[10:6]
- o_PCSrcD  out  1  redirect fetch this cycle
- o_PCNextD  out  ADDRESS_WIDTH  redirect target

## Operation
- IF/ID register: on each rising edge, FlushD loads Instr=0, PCPlus4=0, Valid=0; else StallD holds; else loads InstrF, PCPlus4F, Valid=1. FlushD wins over StallD.
- Register file: 2 combinational read ports (rs=instr[25:21], rt=instr[20:16]), 1 synchronous write port. Register 0 reads 0 always; writes to it ignored. Write-through: if RegWriteW and WriteRegW equals a nonzero read index in the same cycle, read returns ResultW.
- Forward muxes per select encoding; o_SrcAD/o_SrcBD are mux outputs and feed all comparisons.
- Comparisons are signed two's complement on SrcA (and SrcB for EQ/NE).
- Branch ops: NONE, BEQ (A==B), BNE (A!=B), BLTZ (A<0), BGEZ (A≥0), BLEZ (A≤0), BGTZ (A>0), J, JAL, JR, JALR; other codes behave as NONE.
- Targets: branch = PCPlus4D + (SignImm<<2), modulo 2**ADDRESS_WIDTH; J/JAL = {PCPlus4D[top 4], instr[25:0], 00}; JR/JALR = SrcA[ADDRESS_WIDTH-1:0].
- o_PCSrcD = Valid & condition (jumps unconditional); o_PCNextD = target of the selected op, PCPlus4D when no op.

## Timing
- Reset (async assert, sync-safe deassert on i_CLK): IF/ID Instr=0, PCPlus4=0, Valid=0; all registers 0. Hence o_InstrD=0, o_PCPlus4D=0, o_ValidD=0, o_SrcAD=o_SrcBD=0, o_SignImmD=0, o_ShamtD=0, o_PCSrcD=0, o_PCNextD=0 until first load.
- Latency: InstrF captured at edge N; all decode outputs valid combinationally in cycle N+1.
- Register write occurs at edge; write-through covers same-cycle read, so no half-cycle clocking.
- Reset mid-operation aborts any pending redirect; o_PCSrcD drops asynchronously.
- Stall holds outputs stable except for forwarded/RF values, which track current WB/MEM inputs.

## Structure
- Package decode_pkg: branch op encoding localparams, forward select encoding localparams, NOP instruction constant.
- One sub-module: regfile_wt (parametrised 2R1W register file with zero register and write-through).

## Test plan
- Reset while IF/ID loaded with BEQ taken -> o_ValidD=0, o_PCSrcD=0, o_PCNextD=0 immediately.
- RF write r5=0x1234 with same-cycle read of r5 -> o_SrcAD=0x1234; write r0=0xFFFF -> read r0 = 0.
- BEQ, SrcA from ForwardAD=1 ALUOutM=7, rt=7, imm=0xFFFF, PCPlus4=0x100 -> o_PCSrcD=1, o_PCNextD=0xFC.
- BLTZ with SrcA=0x80000000 -> taken; BGTZ same operand -> not taken; BLEZ with 0 -> taken.
- StallD and FlushD asserted together -> next cycle o_InstrD=0, o_ValidD=0; StallD alone -> o_InstrD unchanged for 3 cycles.
- JR with ForwardAD=2, ResultW=0x00400020 -> o_PCSrcD=1, o_PCNextD=0x00400020; J instr[25:0]=0x10, PCPlus4=0x40000004 -> 0x40000040.
